// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues req/gnt/rvalid word fetches
// and buffers returned words in a DEPTH-entry queue. Optional macro: FETCH_PERF_CNT_EN.
module fetch_prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_idata,
  output logic [31:0] if_pc,
  input  logic        if_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_starve_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  // Three ring pointers: head (pop), fill (next PENDING slot), tail (next free slot).
  // Slots in [head, fill) are FULL, slots in [fill, tail) are PENDING.
  logic [AW:0]  head, fill, tail;
  logic [31:0]  pc_mem   [DEPTH];
  logic [31:0]  data_mem [DEPTH];
  logic [31:0]  fetch_pc;
  logic [15:0]  discard;
  logic         run;

  logic [AW:0]  occupancy, outstanding;
  logic         grant, rsp_ok, rsp_drop, rsp_fill, pop;

  assign occupancy   = tail - head;
  assign outstanding = tail - fill;

  // Handshakes: a fetch transfers on imem_req & imem_gnt, a response on imem_rvalid,
  // and an instruction leaves the queue on if_valid & if_ready; req/valid never wait on
  // their own gnt/ready, and imem_addr holds while imem_req is high without imem_gnt.
  assign imem_req  = run && (occupancy < DEPTH_W) && !redirect_valid;
  assign imem_addr = fetch_pc;
  assign grant     = imem_req && imem_gnt;

  assign rsp_drop = imem_rvalid && (discard != 16'd0);
  assign rsp_fill = imem_rvalid && (discard == 16'd0) && (outstanding != '0);
  assign rsp_ok   = rsp_drop || rsp_fill;

  assign if_valid = (fill != head) && !redirect_valid;
  assign if_idata = data_mem[head[AW-1:0]];
  assign if_pc    = pc_mem[head[AW-1:0]];
  assign pop      = if_valid && if_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run      <= 1'b0;
      fetch_pc <= RESET_PC;
      head     <= '0;
      fill     <= '0;
      tail     <= '0;
      discard  <= 16'd0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= 32'd0;
        data_mem[i] <= 32'd0;
      end
    end else begin
      run <= 1'b1;
      if (redirect_valid) begin
        // Every request still in flight must be swallowed, except a word arriving now.
        fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
        head     <= '0;
        fill     <= '0;
        tail     <= '0;
        discard  <= discard + 16'(outstanding) - 16'(rsp_ok);
      end else begin
        if (grant) begin
          pc_mem[tail[AW-1:0]] <= fetch_pc;
          tail                 <= tail + PTR_ONE;
          fetch_pc             <= fetch_pc + 32'd4;
        end
        if (rsp_drop) begin
          discard <= discard - 16'd1;
        end else if (rsp_fill) begin
          data_mem[fill[AW-1:0]] <= imem_rdata;
          fill                   <= fill + PTR_ONE;
        end
        if (pop) begin
          head <= head + PTR_ONE;
        end
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_starve_cnt <= 32'd0;
      perf_flush_cnt  <= 32'd0;
    end else begin
      if (if_ready && !if_valid && (perf_starve_cnt != 32'hFFFF_FFFF)) begin
        perf_starve_cnt <= perf_starve_cnt + 32'd1;
      end
      if (redirect_valid && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

  // A response with nothing outstanding and nothing to discard is a memory-side protocol error.
  rvalid_has_owner: assert property (@(posedge clk) disable iff (!reset)
    imem_rvalid |-> ((discard != 16'd0) || (outstanding != '0)));

endmodule
